mem_responder: RTL
==================

Name: mem_responder

Overview:
- Target-side end of the CPU memory bus (start/address/data/we in, q/busy out).
- Serves each CPU request from one of three regions:
  - an internal wait-stated single-port RAM;
  - a 16-word I/O window, forwarded to peripherals over a req/ack handshake with timeout;
  - an unmapped region, answered immediately with an error.
- Sits between the CPU and the memory/peripheral fabric in the top level.

Parameters:
- RAM_AW, 10, RAM word-address width (RAM depth 2^RAM_AW words; legal range 1..26).
- WAIT_CYCLES, 2, wait states inserted before each RAM access (0 allowed).
- IO_BASE, 27'h7000000, base of the I/O window (16-word aligned; bits [3:0] ignored).
- IO_TIMEOUT, 255, cycles to wait for io_ack before aborting (≥1).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- start  in  1  request strobe from the CPU, one cycle long.
- address  in  27  word address, valid while start=1.
- data  in  32  write data, valid while start=1.
- we  in  1  1=write, 0=read, valid while start=1.
- q  out  32  read data, registered.
- busy  out  1  request in progress.
- io_req  out  1  I/O request, held high until ack or timeout.
- io_addr  out  4  I/O register index, equal to latched address[3:0].
- io_wdata  out  32  I/O write data.
- io_we  out  1  I/O write enable, qualified by io_req.
- io_rdata  in  32  peripheral read data, valid with io_ack.
- io_ack  in  1  peripheral completion, single cycle.
- err_clr  in  1  clears bus_err.
- bus_err  out  1  sticky error flag (unmapped access or I/O timeout).

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE; io_req=0, io_we=0, busy_r=0, bus_err=0, q=0.
  - A RAM write pending in the same cycle is suppressed; RAM contents are not cleared.
  - Reset has priority over every other event.
- Busy output:
  - busy = busy_r | (start & state==IDLE), combinational.
  - The CPU therefore sees busy in the same cycle it pulses start.
- Acceptance:
  - Only in IDLE with start=1. The edge latches address, data and we, and sets busy_r=1.
  - start while not IDLE is ignored; the in-flight request is unaffected.
- Region decode, on the latched address:
  - RAM when address < 2^RAM_AW.
  - Else IO when address[26:4]==IO_BASE[26:4].
  - Else UNMAPPED.
- States: IDLE, RAM_WAIT, RAM_ACC, RAM_RESP, IO_WAIT, ERR.
- RAM path:
  - IDLE→RAM_WAIT, with wait counter loaded to WAIT_CYCLES-1. If WAIT_CYCLES=0, go directly to RAM_ACC.
  - RAM_WAIT decrements the counter; when counter=0, go to RAM_ACC.
  - RAM_ACC: RAM enabled. A write commits at this edge; a read registers RAM output. Go to RAM_RESP.
  - RAM_RESP: on a read, q ← RAM output; on a write, q holds its old value. busy_r←0, go to IDLE.
  - Busy is high for 1 + WAIT_CYCLES + 2 cycles. q is valid in the first cycle busy is low.
- IO path:
  - IDLE→IO_WAIT: io_req=1 with io_addr, io_wdata and io_we from the latched values; timeout counter reset to 0.
  - io_ack sampled high: on a read, q ← io_rdata; on a write, q holds. io_req←0, busy_r←0, go to IDLE.
  - Counter reaches IO_TIMEOUT without ack: q←0, bus_err←1, io_req←0, busy_r←0, go to IDLE.
  - io_ack while not in IO_WAIT is ignored.
  - io_ack on the same edge the timeout fires: ack wins and no error is raised.
- Unmapped path:
  - IDLE→ERR. At the ERR edge: q←0 (reads), bus_err←1, busy_r←0, go to IDLE.
  - Busy is high for 2 cycles.
  - Unmapped writes are dropped and leave q unchanged.
- bus_err:
  - Cleared by err_clr=1.
  - A set on the same edge as err_clr wins.
- Counters never wrap; each saturates at its terminal value.

Decomposition:
- Shared package mem_responder_pkg:
  - state enum;
  - region enum (REG_RAM, REG_IO, REG_UNMAPPED);
  - the address and data width constants (27, 32), also used by the CPU side.
- One sub-module, mem_responder_ram:
  - inferred single-port synchronous RAM;
  - 2^RAM_AW×32, one-cycle read latency, write-first disabled (read returns the old data).

Test Plan:
- RAM write then read, WAIT_CYCLES=2:
  - Stimulus: write 0x12345678 @0x005, then read @0x005.
  - Required: busy high exactly 5 cycles per access; q=0x12345678 in the first cycle busy is low.
- WAIT_CYCLES=0:
  - Stimulus: read @0x3FF.
  - Required: busy high 3 cycles.
  - Read @0x400 (just beyond RAM, outside IO): bus_err=1, q=0, busy high 2 cycles.
- IO read:
  - Stimulus: read @0x7000003; io_ack after 3 cycles with io_rdata=0xCAFEF00D.
  - Required: io_addr=3, io_we=0; q=0xCAFEF00D; io_req drops on the ack edge.
- IO timeout, IO_TIMEOUT=4:
  - Stimulus: write @0x7000001, never ack.
  - Required: io_req high 4 cycles, then bus_err=1 and busy low.
  - Then assert err_clr → bus_err=0.
- Protocol corner cases:
  - start pulsed while busy is ignored: RAM content unchanged, and only one response is returned.
  - reset=0 during RAM_ACC of a write to @0x010: busy=0 on the next cycle; a subsequent read @0x010 returns the old value.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the CPU memory bus target: bus widths,
// responder FSM states, address regions and the region decoder.
package mem_responder_pkg;

  localparam int unsigned ADDR_W = 27;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RAM_WAIT = 3'd1,
    RAM_ACC  = 3'd2,
    RAM_RESP = 3'd3,
    IO_WAIT  = 3'd4,
    ERR      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    REG_RAM      = 2'd0,
    REG_IO       = 2'd1,
    REG_UNMAPPED = 2'd2
  } region_t;

  // RAM wins over the I/O window if the two ever overlap.
  function automatic region_t decode_region(input logic [ADDR_W-1:0] addr,
                                            input int unsigned       ram_aw,
                                            input logic [ADDR_W-5:0] io_page);
    if ((addr >> ram_aw) == '0) return REG_RAM;
    else if (addr[ADDR_W-1:4] == io_page) return REG_IO;
    else return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous RAM, one-cycle read latency; a read during a write
// to the same word returns the previous contents.
module mem_responder_ram
  import mem_responder_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              wr,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (wr) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// CPU memory bus target: serves requests from a wait-stated RAM, a 16-word
// I/O window with req/ack handshake and timeout, or answers with an error.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned       RAM_AW      = 10,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] IO_BASE     = 27'h7000000,
  parameter int unsigned       IO_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              we,
  output logic [DATA_W-1:0] q,
  output logic              busy,
  output logic              io_req,
  output logic [3:0]        io_addr,
  output logic [DATA_W-1:0] io_wdata,
  output logic              io_we,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic              io_ack,
  input  logic              err_clr,
  output logic              bus_err
);

  localparam int unsigned WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned TCNT_W = $clog2(IO_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(IO_TIMEOUT - 1);

  state_t              state;
  logic                busy_r;
  logic [RAM_AW-1:0]   ram_addr;
  logic [3:0]          io_idx;
  logic [DATA_W-1:0]   wdata_l;
  logic                we_l;
  logic [WCNT_W-1:0]   wcnt;
  logic [TCNT_W-1:0]   tcnt;
  logic                ram_en;
  logic [DATA_W-1:0]   ram_rdata;

  assign busy     = busy_r | (start & (state == IDLE));
  assign io_addr  = io_idx;
  assign io_wdata = wdata_l;
  assign io_we    = io_req & we_l;
  // Gating with reset keeps a write in RAM_ACC from committing on a reset edge.
  assign ram_en   = (state == RAM_ACC) & reset;

  mem_responder_ram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .wr    (we_l),
    .addr  (ram_addr),
    .wdata (wdata_l),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      busy_r  <= 1'b0;
      io_req  <= 1'b0;
      bus_err <= 1'b0;
      q       <= '0;
    end else begin
      // Error sets below are later in the block, so they override a clear.
      if (err_clr) bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ram_addr <= address[RAM_AW-1:0];
            io_idx   <= address[3:0];
            wdata_l  <= data;
            we_l     <= we;
            busy_r   <= 1'b1;
            case (decode_region(address, RAM_AW, IO_BASE[ADDR_W-1:4]))
              REG_RAM: begin
                if (WAIT_CYCLES == 0) begin
                  state <= RAM_ACC;
                end else begin
                  state <= RAM_WAIT;
                  wcnt  <= WAIT_LOAD;
                end
              end
              REG_IO: begin
                state  <= IO_WAIT;
                io_req <= 1'b1;
                tcnt   <= '0;
              end
              default: state <= ERR;
            endcase
          end
        end
        RAM_WAIT: begin
          if (wcnt == '0) state <= RAM_ACC;
          else wcnt <= wcnt - 1'b1;
        end
        RAM_ACC: state <= RAM_RESP;
        RAM_RESP: begin
          if (!we_l) q <= ram_rdata;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        IO_WAIT: begin
          if (io_ack) begin
            if (!we_l) q <= io_rdata;
            io_req <= 1'b0;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else if (tcnt == TCNT_LAST) begin
            q       <= '0;
            bus_err <= 1'b1;
            io_req  <= 1'b0;
            busy_r  <= 1'b0;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ERR: begin
          if (!we_l) q <= '0;
          bus_err <= 1'b1;
          busy_r  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          io_req <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
